// File: rtl/disp_time_7seg_scan.sv
// disp_time_7seg_scan
//   Samples the packed 12-hour time word once per display frame, converts
//   hr/min/sec to BCD with a sequential subtract-10 engine and scans a
//   6-digit common-anode seven-segment display (HH MM SS), all on kh_clk.
//
// Ports
//   kh_clk     in   1   1 kHz clock, rising edge
//   reset      in   1   asynchronous, active-high
//   disp_time  in   27  {hr[26:22], min[21:16], sec[15:10], ms[9:0]} (ms unused)
//   an_n       out  6   digit enables, active-low; bit0 = sec ones, bit5 = hr tens
//   seg_n      out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp_n       out  1   decimal point, active-low
//   range_err  out  1   displayed word had an out-of-range field
//
// Build option
//   DP_BLINK_EN  when defined, dp_n lights the hr/min and min/sec separators
//                (digits 4 and 2) while the displayed seconds value is even.
module disp_time_7seg_scan #(
  parameter int unsigned SCAN_DIV      = 2,
  parameter int unsigned HR_MAX        = 11,
  parameter bit          HR_ZERO_AS_12 = 1'b1
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic [26:0] disp_time,
  output logic [5:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        range_err
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0]      HR_MAX_L = HR_MAX[4:0];
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [6:0]      SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, LATCH, CONV, DONE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Scan counter
  logic [DIV_W-1:0] div_cnt_q;
  logic [2:0]       dig_q;
  logic             frame_start;

  assign frame_start = (dig_q == 3'd0) && (div_cnt_q == '0);

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
      dig_q     <= (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Conversion FSM with working and shadow registers
  state_t           state_q;
  logic [4:0]       hr_w_q;
  logic [5:0]       min_w_q;
  logic [5:0]       sec_w_q;
  logic [2:0]       hr_t_q;
  logic [2:0]       min_t_q;
  logic [2:0]       sec_t_q;
  logic             hr_bad_q;
  logic             min_bad_q;
  logic             sec_bad_q;
  logic [5:0][6:0]  shadow_seg_q;
  logic             shadow_err_q;
  logic             shadow_valid_q;
`ifdef DP_BLINK_EN
  logic             shadow_dp_q;
`endif

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      hr_w_q         <= '0;
      min_w_q        <= '0;
      sec_w_q        <= '0;
      hr_t_q         <= '0;
      min_t_q        <= '0;
      sec_t_q        <= '0;
      hr_bad_q       <= 1'b0;
      min_bad_q      <= 1'b0;
      sec_bad_q      <= 1'b0;
      shadow_seg_q   <= '1;
      shadow_err_q   <= 1'b0;
      shadow_valid_q <= 1'b0;
`ifdef DP_BLINK_EN
      shadow_dp_q    <= 1'b0;
`endif
    end else begin
      // Commit consumes the shadow on every frame boundary.
      if (frame_start) shadow_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Sample on the frame boundary itself so the word paired with a
          // commit is the one present on that same edge.
          if (frame_start) begin
            hr_w_q  <= disp_time[26:22];
            min_w_q <= disp_time[21:16];
            sec_w_q <= disp_time[15:10];
            state_q <= LATCH;
          end
        end
        LATCH: begin
          hr_t_q    <= '0;
          min_t_q   <= '0;
          sec_t_q   <= '0;
          hr_bad_q  <= hr_w_q > HR_MAX_L;
          min_bad_q <= min_w_q > 6'd59;
          sec_bad_q <= sec_w_q > 6'd59;
          if (HR_ZERO_AS_12 && (hr_w_q == '0)) hr_w_q <= 5'd12;
          state_q   <= CONV;
        end
        CONV: begin
          if ((hr_w_q < 5'd10) && (min_w_q < 6'd10) && (sec_w_q < 6'd10)) begin
            state_q <= DONE;
          end else begin
            if (hr_w_q >= 5'd10) begin
              hr_w_q <= hr_w_q - 5'd10;
              hr_t_q <= hr_t_q + 3'd1;
            end
            if (min_w_q >= 6'd10) begin
              min_w_q <= min_w_q - 6'd10;
              min_t_q <= min_t_q + 3'd1;
            end
            if (sec_w_q >= 6'd10) begin
              sec_w_q <= sec_w_q - 6'd10;
              sec_t_q <= sec_t_q + 3'd1;
            end
          end
        end
        DONE: begin
          shadow_seg_q[5] <= hr_bad_q ? SEG_DASH :
                             ((hr_t_q == '0) ? SEG_BLANK : seg7({1'b0, hr_t_q}));
          shadow_seg_q[4] <= hr_bad_q  ? SEG_DASH : seg7(hr_w_q[3:0]);
          shadow_seg_q[3] <= min_bad_q ? SEG_DASH : seg7({1'b0, min_t_q});
          shadow_seg_q[2] <= min_bad_q ? SEG_DASH : seg7(min_w_q[3:0]);
          shadow_seg_q[1] <= sec_bad_q ? SEG_DASH : seg7({1'b0, sec_t_q});
          shadow_seg_q[0] <= sec_bad_q ? SEG_DASH : seg7(sec_w_q[3:0]);
          shadow_err_q    <= hr_bad_q | min_bad_q | sec_bad_q;
`ifdef DP_BLINK_EN
          // Tens contribute multiples of 10, so ones parity is seconds parity.
          shadow_dp_q     <= ~sec_bad_q & ~sec_w_q[0];
`endif
          shadow_valid_q  <= 1'b1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display registers and registered outputs
  logic [5:0][6:0] disp_seg_q, disp_seg_d;
  logic            range_err_q, range_err_d;
  logic [5:0]      an_n_q;
  logic [6:0]      seg_n_q;
  logic            dp_n_q;
`ifdef DP_BLINK_EN
  logic            disp_dp_q, disp_dp_d;
`endif

  always_comb begin
    disp_seg_d  = disp_seg_q;
    range_err_d = range_err_q;
`ifdef DP_BLINK_EN
    disp_dp_d   = disp_dp_q;
`endif
    if (frame_start && shadow_valid_q) begin
      disp_seg_d  = shadow_seg_q;
      range_err_d = shadow_err_q;
`ifdef DP_BLINK_EN
      disp_dp_d   = shadow_dp_q;
`endif
    end
  end

  // Segments come from the post-commit value so digit 0 of a new frame
  // already shows the new word and no frame mixes old and new digits.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      disp_seg_q  <= '1;
      range_err_q <= 1'b0;
      an_n_q      <= '1;
      seg_n_q     <= '1;
      dp_n_q      <= 1'b1;
`ifdef DP_BLINK_EN
      disp_dp_q   <= 1'b0;
`endif
    end else begin
      disp_seg_q  <= disp_seg_d;
      range_err_q <= range_err_d;
      an_n_q      <= ~(6'd1 << dig_q);
      seg_n_q     <= disp_seg_d[dig_q];
`ifdef DP_BLINK_EN
      disp_dp_q   <= disp_dp_d;
      dp_n_q      <= ~(disp_dp_d && ((dig_q == 3'd2) || (dig_q == 3'd4)));
`else
      dp_n_q      <= 1'b1;
`endif
    end
  end

  assign an_n      = an_n_q;
  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;
  assign range_err = range_err_q;

endmodule

// File: doc/disp_time_7seg_scan.md
Name: disp_time_7seg_scan

Overview:
- Downstream consumer of the 12-hour clock's packed 27-bit `disp_time` bus.
- Once per display frame, samples the time word and converts hr/min/sec to BCD with a sequential repeated-subtract-10 engine.
- Drives a 6-digit multiplexed common-anode seven-segment display showing HH MM SS.
- Runs entirely in the 1 kHz `kh_clk` domain.

Parameters:
- SCAN_DIV, 2, `kh_clk` cycles each digit is lit; frame = 6*SCAN_DIV cycles; must be >= 2.
- HR_MAX, 11, largest legal hr value; hr > HR_MAX is out of range.
- HR_ZERO_AS_12, 1, when 1, hr==0 is displayed as 12.

Ports:
- kh_clk  input  1  1 kHz clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- disp_time  input  27  packed {hr[26:22], min[21:16], sec[15:10], ms[9:0]}; ms is ignored.
- an_n  output  6  digit enables, active-low; bit0 = sec ones (rightmost), bit5 = hr tens.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- range_err  output  1  high while the displayed word contained any out-of-range field.

Interface: reset is `reset`, asynchronous, active-high; clock is `kh_clk`.

Behaviour:
- Reset values:
  - an_n = 6'b111111, seg_n = 7'b1111111, dp_n = 1, range_err = 0.
  - div_cnt = 0, dig = 0.
  - Display and shadow registers = blank; shadow_valid = 0; FSM in IDLE.
- Scan counter:
  - div_cnt counts 0..SCAN_DIV-1.
  - On wrap, dig advances 0..5, then wraps to 0.
  - frame_start = (dig==0 && div_cnt==0).
- Output registers:
  - an_n, seg_n and dp_n are registered from the current dig and display registers.
  - Exactly one an_n bit is low each cycle after reset; it is never low outside reset-released operation.
- Conversion FSM, states IDLE -> LATCH -> CONV -> DONE -> IDLE:
  - IDLE: on frame_start, go to LATCH.
  - LATCH (1 cycle): capture hr, min, sec into working regs; clear the tens counters.
  - CONV: per cycle, each field with value >= 10 subtracts 10 and increments its tens counter. All three fields run in parallel. Exit when all three are < 10; the residue becomes ones.
  - DONE (1 cycle): write the BCD digits and range flags to the shadow regs; set shadow_valid.
  - Worst case is field 63: LATCH + 7 CONV + DONE = 9 cycles, which is less than the minimum frame of 12.
- Commit:
  - On frame_start with shadow_valid=1, copy shadow to display regs and update range_err; clear shadow_valid.
  - Latency: a word sampled at frame k is shown from frame k+1. The display changes only at frame boundaries (no tearing).
  - The FSM's LATCH on the same frame_start uses current `disp_time`; commit and new sample coincide.
- First display after reset release: the commit at the second frame_start (cycle 6*SCAN_DIV). Blank before that.
- Range rules:
  - hr > HR_MAX: both hr digits show dash (7'b0111111).
  - min > 59 or sec > 59: that field's digits show dash.
  - range_err = OR of the three flags.
- Hour display:
  - If HR_ZERO_AS_12 and hr==0, show "12".
  - Hr tens blanked (7'b1111111) when it is 0.
  - Min/sec tens are never blanked.
- Segment codes (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-conversion or mid-frame: immediate return to the reset values; the partial shadow is discarded.
- `disp_time` changing during CONV has no effect (working regs already latched).

Optional Feature:
- Macro `DP_BLINK_EN`.
- Defined: dp_n is low on digits 2 and 4 (hr/min and min/sec separators) when the committed sec value is even, high when odd. Out-of-range sec forces dp_n high.
- Undefined: dp_n held high at all times.

Test Plan:
- Reset release, then `disp_time` = {5'd3, 6'd7, 6'd45, 10'd123}, SCAN_DIV=2:
  - Blank until cycle 12.
  - Then digits 5..0 = blank, 3, 0, 7, 4, 5.
  - an_n cycles 111110 -> 111101 -> ... every 2 cycles; range_err = 0.
- hr=0, min=0, sec=0 with HR_ZERO_AS_12=1 -> display "12 00 00"; with HR_ZERO_AS_12=0 -> display " 0 00 00" (hr tens blank).
- hr=11, min=59, sec=59:
  - Conversion completes in 1+6+1 = 8 cycles.
  - Display "11 59 59" from the next frame; range_err = 0.
- min=63, sec=60, hr=20:
  - All three fields show "--".
  - range_err = 1 for that frame, then clears after a legal word commits.
- Change `disp_time` from 1:00:00 to 1:00:01 during the CONV cycles:
  - The next frame shows 1:00:00.
  - The following frame shows 1:00:01, with no mixed digits.
- Assert reset mid-CONV for 1 cycle:
  - Outputs immediately take their reset values.
  - The previous shadow is not committed.
  - The first new display appears 12 cycles after release.
